preempt_irq_ctrl: RTL and testbench
===================================

// Module: preempt_irq_ctrl
// PURPOSE
//  Parametrised successor to the single-quantum context-switch timer. Runs a loadable preemption quantum
//  and arbitrates N_IRQ maskable external interrupt lines.
//  Issues the save_pc -> ctx_switch pulse pair to the PC/register-bank datapath, with a cause code.
//  Sits beside the control unit; decodes only the opcode field inst.
// PARAMETERS
//  OPW            6          opcode width
//  QW             8          quantum counter/register width
//  QUANTUM_RST    80         quantum register value after reset
//  N_IRQ          4          external interrupt lines (>=1); IW = max(1,$clog2(N_IRQ))
//  OP_PRE_ON      6'b100100  enable preemption
//  OP_PRE_OFF     6'b100101  disable preemption
//  OP_SYSCALL     6'b011001  immediate context switch
//  OP_IN/OP_OUT   6'b010110/6'b010111  I/O opcodes; cycles carrying them do not consume quantum
// PORTS
//  clock        in   1      single clock, rising edge
//  reset        in   1      asynchronous, active-high
//  inst         in   OPW    opcode of current instruction
//  io_in/io_out in   1      I/O request strobes
//  controlIO    in   1      I/O device not ready
//  quantum_load in   1      load quantum_val into quantum register
//  quantum_val  in   QW     new quantum; 0 ignored
//  irq_req      in   N_IRQ  level interrupt requests
//  irq_mask     in   N_IRQ  1 = line masked
//  controlPC    out  2      PC select: 10 I/O stall, 01 switch vector, 00 sequential
//  preempt_en   out  1      preemption enabled
//  save_pc      out  1      one-cycle pulse: latch return PC
//  ctx_switch   out  1      one-cycle pulse: perform switch
//  cause        out  2      valid with ctx_switch: 01 quantum, 10 irq, 11 syscall; else 00
//  irq_id       out  IW     serviced line, valid with ctx_switch
//  irq_pending  out  N_IRQ  sticky pending bits
// BEHAVIOUR
//  - Reset: state IDLE; count=0; quantum=QUANTUM_RST; pending=0. preempt_en, save_pc, ctx_switch, cause,
//    irq_id all 0. controlPC is combinational, so it reads 00 unless the I/O stall condition holds.
//  - controlPC = 10 when (io_in|io_out)&controlIO; else 01 during SWITCH; else 00.
//  - pending <= pending | (irq_req & ~irq_mask) every cycle. Masking does not clear a latched bit.
//  - States: IDLE (preempt off), RUN (counting), SAVE (save_pc=1), SWITCH (ctx_switch=1). All outputs registered.
//  - Event priority per edge: reset > SYSCALL > PRE_OFF > IRQ > quantum expiry.
//  - SYSCALL (any state) -> SWITCH next cycle with cause 11. No SAVE. Also count=0 and preempt_en=0.
//  - IDLE: PRE_ON -> RUN, preempt_en=1, count=0.
//  - RUN: PRE_OFF -> IDLE, preempt_en=0, count=0.
//  - IDLE/RUN: any pending bit -> SAVE.
//    - Lowest-index pending line wins; latch irq_id; cause=10.
//  - RUN quantum: count increments only when inst is not OP_IN/OP_OUT.
//    - When count >= quantum-1 on an eligible cycle -> SAVE with cause=01 and count=0.
//    - With no stalls: save_pc in cycle Q+1, ctx_switch in cycle Q+2 after entering RUN.
//  - SAVE -> SWITCH unconditionally (only reset or SYSCALL intervene).
//  - SWITCH -> RUN if preempt_en, else IDLE. The serviced pending bit is cleared in the SWITCH cycle.
//    An IRQ re-asserted in that same cycle re-latches.
//  - IRQs arriving during SAVE/SWITCH stay pending; serviced on the first IDLE/RUN cycle after.
//  - quantum_load (nonzero) updates the register at the next edge and applies at once.
//    If the new value is <= count+1, expiry fires on the next eligible cycle.
//  - Count never wraps: the >= comparison bounds it to quantum-1.
//  - Reset mid-SAVE/SWITCH aborts with no further pulse.
// STRUCTURE
//  - Package preempt_pkg: opcode localparams, cause codes (CAUSE_NONE/QUANTUM/IRQ/SYSCALL),
//    state encoding (IDLE/RUN/SAVE/SWITCH).
//  - Sub-module irq_prio_enc (N_IRQ): pending & ~mask -> {any, idx}, lowest index wins; purely combinational.
// TESTING
//  - Reset, PRE_ON, quantum=80, no I/O -> save_pc at cycle 81, ctx_switch+cause=01 at 82, then repeat every 82.
//  - Same, with OP_IN held 5 cycles mid-quantum -> both pulses delayed by exactly 5 cycles.
//  - irq_req=4'b0110 unmasked during RUN -> SAVE, then SWITCH with irq_id=1, cause=10.
//    Bit1 clears; line 2 serviced next.
//  - SYSCALL on the same cycle as expiry -> single ctx_switch, cause=11, preempt_en=0, no save_pc.
//  - quantum_load=3 while count=10 -> save_pc next eligible cycle; quantum_val=0 -> register unchanged.
//  - Assert reset during SAVE -> all outputs 0 immediately (async); no ctx_switch follows.

Source files
------------

// File: rtl/preempt_irq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package : preempt_pkg
// Purpose : Shared constants for the preemption / interrupt controller:
//           default opcodes, switch cause codes and FSM state encoding.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package preempt_pkg;

  // Default opcode encodings (6-bit opcode field)
  localparam logic [5:0] PKG_OP_PRE_ON  = 6'b100100;
  localparam logic [5:0] PKG_OP_PRE_OFF = 6'b100101;
  localparam logic [5:0] PKG_OP_SYSCALL = 6'b011001;
  localparam logic [5:0] PKG_OP_IN      = 6'b010110;
  localparam logic [5:0] PKG_OP_OUT     = 6'b010111;

  // Context-switch cause codes
  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_QUANTUM = 2'b01;
  localparam logic [1:0] CAUSE_IRQ     = 2'b10;
  localparam logic [1:0] CAUSE_SYSCALL = 2'b11;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SAVE   = 2'd2,
    ST_SWITCH = 2'd3
  } state_t;

endpackage : preempt_pkg
`default_nettype wire

// File: rtl/preempt_irq_ctrl_prio_enc.sv
`default_nettype none
// ============================================================================
// Module  : irq_prio_enc
// Purpose : Fixed-priority encoder over unmasked pending interrupt lines.
//           The lowest-index active line wins. Purely combinational.
// Ports   : pending [N_IRQ] in  - latched pending bits
//           mask    [N_IRQ] in  - 1 = line masked
//           any           out - at least one unmasked line pending
//           idx     [IW]  out - index of the winning line (0 when none)
// Rev     : 1.0  initial release
// ============================================================================
module irq_prio_enc
  import preempt_pkg::*;
#(
  parameter int N_IRQ = 4,
  parameter int IW    = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
)(
  input  logic [N_IRQ-1:0] pending,
  input  logic [N_IRQ-1:0] mask,
  output logic             any,
  output logic [IW-1:0]    idx
);

  logic [N_IRQ-1:0] w_req;

  assign w_req = pending & ~mask;

  // Scan from the top down so the lowest active index is the last write.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_req[i]) begin
        any = 1'b1;
        idx = IW'(i);
      end
    end
  end

endmodule : irq_prio_enc
`default_nettype wire

// File: rtl/preempt_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : preempt_irq_ctrl
// Purpose : Preemption quantum timer plus maskable interrupt arbiter. Issues a
//           save_pc -> ctx_switch pulse pair with a cause code to the PC /
//           register-bank datapath.
// Ports   : clock, reset (async, active-high)
//           inst[OPW]          opcode of current instruction
//           io_in, io_out      I/O request strobes; controlIO = device not ready
//           quantum_load/val   load a new (nonzero) quantum
//           irq_req/irq_mask   level requests and per-line masks
//           controlPC[2]       10 I/O stall, 01 switch vector, 00 sequential
//           preempt_en         preemption enabled
//           save_pc/ctx_switch one-cycle pulses
//           cause[2], irq_id   valid with ctx_switch
//           irq_pending[N_IRQ] sticky pending bits
// Rev     : 1.0  initial release
// ============================================================================
module preempt_irq_ctrl
  import preempt_pkg::*;
#(
  parameter int              OPW         = 6,
  parameter int              QW          = 8,
  parameter int              QUANTUM_RST = 80,
  parameter int              N_IRQ       = 4,
  parameter logic [OPW-1:0]  OP_PRE_ON   = OPW'(PKG_OP_PRE_ON),
  parameter logic [OPW-1:0]  OP_PRE_OFF  = OPW'(PKG_OP_PRE_OFF),
  parameter logic [OPW-1:0]  OP_SYSCALL  = OPW'(PKG_OP_SYSCALL),
  parameter logic [OPW-1:0]  OP_IN       = OPW'(PKG_OP_IN),
  parameter logic [OPW-1:0]  OP_OUT      = OPW'(PKG_OP_OUT),
  localparam int             IW          = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
)(
  input  logic             clock,
  input  logic             reset,
  input  logic [OPW-1:0]   inst,
  input  logic             io_in,
  input  logic             io_out,
  input  logic             controlIO,
  input  logic             quantum_load,
  input  logic [QW-1:0]    quantum_val,
  input  logic [N_IRQ-1:0] irq_req,
  input  logic [N_IRQ-1:0] irq_mask,
  output logic [1:0]       controlPC,
  output logic             preempt_en,
  output logic             save_pc,
  output logic             ctx_switch,
  output logic [1:0]       cause,
  output logic [IW-1:0]    irq_id,
  output logic [N_IRQ-1:0] irq_pending
);

  state_t           state;
  logic [QW-1:0]    count;
  logic [QW-1:0]    quantum;
  logic [1:0]       hold_cause;   // cause carried from SAVE into SWITCH
  logic [N_IRQ-1:0] clr;
  logic [N_IRQ-1:0] pending_next;
  logic             irq_any;
  logic [IW-1:0]    irq_idx;
  logic             is_syscall;
  logic             is_pre_on;
  logic             is_pre_off;
  logic             eligible;
  logic             expire;

  irq_prio_enc #(
    .N_IRQ (N_IRQ),
    .IW    (IW)
  ) u_prio_enc (
    .pending (irq_pending),
    .mask    (irq_mask),
    .any     (irq_any),
    .idx     (irq_idx)
  );

  assign is_syscall = (inst == OP_SYSCALL);
  assign is_pre_on  = (inst == OP_PRE_ON);
  assign is_pre_off = (inst == OP_PRE_OFF);
  // I/O instructions do not consume quantum
  assign eligible   = (inst != OP_IN) && (inst != OP_OUT);
  // quantum is never zero, so quantum-1 cannot underflow; >= keeps count bounded
  assign expire     = (count >= (quantum - QW'(1)));

  assign controlPC = ((io_in | io_out) & controlIO) ? 2'b10 :
                     (state == ST_SWITCH)           ? 2'b01 : 2'b00;

  // The serviced line is cleared during SWITCH; a request arriving in that
  // same cycle is OR-ed back in afterwards so it is not lost.
  always_comb begin
    clr = '0;
    if ((state == ST_SWITCH) && (hold_cause == CAUSE_IRQ)) begin
      clr = N_IRQ'(1) << irq_id;
    end
    pending_next = (irq_pending & ~clr) | (irq_req & ~irq_mask);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      count       <= '0;
      quantum     <= QW'(QUANTUM_RST);
      hold_cause  <= CAUSE_NONE;
      irq_pending <= '0;
      preempt_en  <= 1'b0;
      save_pc     <= 1'b0;
      ctx_switch  <= 1'b0;
      cause       <= CAUSE_NONE;
      irq_id      <= '0;
    end else begin
      save_pc     <= 1'b0;
      ctx_switch  <= 1'b0;
      cause       <= CAUSE_NONE;
      irq_pending <= pending_next;

      if (quantum_load && (quantum_val != '0)) begin
        quantum <= quantum_val;
      end

      if (is_syscall) begin
        state      <= ST_SWITCH;
        ctx_switch <= 1'b1;
        cause      <= CAUSE_SYSCALL;
        hold_cause <= CAUSE_SYSCALL;
        count      <= '0;
        preempt_en <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            count <= '0;
            if (is_pre_on) begin
              preempt_en <= 1'b1;
            end
            if (irq_any) begin
              state      <= ST_SAVE;
              save_pc    <= 1'b1;
              hold_cause <= CAUSE_IRQ;
              irq_id     <= irq_idx;
            end else if (is_pre_on) begin
              state <= ST_RUN;
            end
          end

          ST_RUN: begin
            if (is_pre_off) begin
              state      <= ST_IDLE;
              preempt_en <= 1'b0;
              count      <= '0;
            end else if (irq_any) begin
              state      <= ST_SAVE;
              save_pc    <= 1'b1;
              hold_cause <= CAUSE_IRQ;
              irq_id     <= irq_idx;
              count      <= '0;
            end else if (eligible) begin
              if (expire) begin
                state      <= ST_SAVE;
                save_pc    <= 1'b1;
                hold_cause <= CAUSE_QUANTUM;
                count      <= '0;
              end else begin
                count <= count + QW'(1);
              end
            end
          end

          ST_SAVE: begin
            state      <= ST_SWITCH;
            ctx_switch <= 1'b1;
            cause      <= hold_cause;
          end

          ST_SWITCH: begin
            state <= preempt_en ? ST_RUN : ST_IDLE;
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule : preempt_irq_ctrl
`default_nettype wire

// File: tb/tb_preempt_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_preempt_irq_ctrl
// Purpose : Directed self-checking bench for preempt_irq_ctrl. Expected
//           values are hand-derived cycle numbers and output codes.
// Rev     : 1.0  initial release
// ============================================================================
module tb_preempt_irq_ctrl;

  localparam int OPW   = 6;
  localparam int QW    = 8;
  localparam int N_IRQ = 4;
  localparam int IW    = 2;

  localparam logic [5:0] OP_NOP     = 6'b000000;
  localparam logic [5:0] OP_PRE_ON  = 6'b100100;
  localparam logic [5:0] OP_PRE_OFF = 6'b100101;
  localparam logic [5:0] OP_SYSCALL = 6'b011001;
  localparam logic [5:0] OP_IN      = 6'b010110;

  logic             clock = 1'b0;
  logic             reset;
  logic [OPW-1:0]   inst;
  logic             io_in, io_out, controlIO;
  logic             quantum_load;
  logic [QW-1:0]    quantum_val;
  logic [N_IRQ-1:0] irq_req, irq_mask;
  logic [1:0]       controlPC;
  logic             preempt_en, save_pc, ctx_switch;
  logic [1:0]       cause;
  logic [IW-1:0]    irq_id;
  logic [N_IRQ-1:0] irq_pending;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;
  int seen;

  preempt_irq_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .inst         (inst),
    .io_in        (io_in),
    .io_out       (io_out),
    .controlIO    (controlIO),
    .quantum_load (quantum_load),
    .quantum_val  (quantum_val),
    .irq_req      (irq_req),
    .irq_mask     (irq_mask),
    .controlPC    (controlPC),
    .preempt_en   (preempt_en),
    .save_pc      (save_pc),
    .ctx_switch   (ctx_switch),
    .cause        (cause),
    .irq_id       (irq_id),
    .irq_pending  (irq_pending)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    inst         = OP_NOP;
    io_in        = 1'b0;
    io_out       = 1'b0;
    controlIO    = 1'b0;
    quantum_load = 1'b0;
    quantum_val  = '0;
    irq_req      = '0;
    irq_mask     = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Advance until save_pc is seen or the absolute cycle limit is reached
  task automatic run_to_save(input int limit);
    while (!save_pc && cyc < limit) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    // ---------------- reset state + quantum 80 period ----------------
    do_reset();
    check("rst_preempt_en", preempt_en, 0);
    check("rst_save_pc", save_pc, 0);
    check("rst_ctx_switch", ctx_switch, 0);
    check("rst_cause", cause, 0);
    check("rst_irq_id", irq_id, 0);
    check("rst_pending", irq_pending, 0);
    check("rst_controlPC", controlPC, 0);

    inst = OP_PRE_ON;
    tick();
    inst = OP_NOP;
    cyc = 1;
    check("pre_on_en", preempt_en, 1);
    run_to_save(300);
    check("q80_save_cycle", cyc, 81);
    check("q80_save_cause", cause, 0);
    tick(); cyc++;
    check("q80_ctx_switch", ctx_switch, 1);
    check("q80_cause", cause, 1);
    check("q80_controlPC", controlPC, 1);
    check("q80_save_off", save_pc, 0);
    run_to_save(400);
    check("q80_second_save", cyc, 163);
    tick(); cyc++;
    check("q80_second_switch", ctx_switch, 1);

    // ---------------- OP_IN stalls the quantum for 5 cycles ----------------
    do_reset();
    inst = OP_PRE_ON;
    tick();
    inst = OP_NOP;
    cyc = 1;
    while (cyc < 10) begin tick(); cyc++; end
    io_in = 1'b1; controlIO = 1'b1;
    #1 check("io_stall_pc", controlPC, 2);
    controlIO = 1'b0;
    #1 check("io_ready_pc", controlPC, 0);
    io_in = 1'b0;
    inst = OP_IN;
    for (int i = 0; i < 5; i++) begin tick(); cyc++; end
    inst = OP_NOP;
    run_to_save(300);
    check("io_save_cycle", cyc, 86);
    tick(); cyc++;
    check("io_switch", ctx_switch, 1);

    // ---------------- IRQ arbitration ----------------
    do_reset();
    inst = OP_PRE_ON;
    tick();
    inst = OP_NOP;
    tick(); tick();
    irq_req = 4'b0110;
    tick();
    irq_req = 4'b0000;
    check("irq_latched", irq_pending, 4'b0110);
    tick();
    check("irq_save", save_pc, 1);
    tick();
    check("irq_switch", ctx_switch, 1);
    check("irq_cause", cause, 2);
    check("irq_id1", irq_id, 1);
    tick();
    check("irq_bit1_cleared", irq_pending, 4'b0100);
    tick();
    check("irq2_save", save_pc, 1);
    tick();
    check("irq2_switch", ctx_switch, 1);
    check("irq2_id", irq_id, 2);
    tick();
    check("irq_all_cleared", irq_pending, 0);
    irq_mask = 4'b1000;
    irq_req  = 4'b1000;
    tick();
    irq_req  = 4'b0000;
    check("irq_masked_pending", irq_pending, 0);
    tick();
    check("irq_masked_nosave", save_pc, 0);
    irq_mask = 4'b0000;
    inst = OP_PRE_OFF;
    tick();
    inst = OP_NOP;
    check("pre_off_en", preempt_en, 0);

    // ---------------- SYSCALL coincident with expiry ----------------
    do_reset();
    inst = OP_PRE_ON;
    tick();
    inst = OP_NOP;
    cyc = 1;
    while (cyc < 80) begin tick(); cyc++; end
    inst = OP_SYSCALL;
    tick();
    inst = OP_NOP;
    check("sys_switch", ctx_switch, 1);
    check("sys_cause", cause, 3);
    check("sys_preempt_off", preempt_en, 0);
    check("sys_no_save", save_pc, 0);
    tick();
    check("sys_single_switch", ctx_switch, 0);
    check("sys_no_save_after", save_pc, 0);

    // ---------------- quantum_load ----------------
    do_reset();
    inst = OP_PRE_ON;
    tick();
    inst = OP_NOP;
    cyc = 1;
    while (cyc < 11) begin tick(); cyc++; end
    quantum_load = 1'b1; quantum_val = 8'd3;
    tick(); cyc++;
    quantum_load = 1'b0;
    check("qload_no_save_yet", save_pc, 0);
    tick(); cyc++;
    check("qload_save", save_pc, 1);
    tick(); cyc++;
    tick(); cyc++;
    quantum_load = 1'b1; quantum_val = 8'd0;
    tick(); cyc++;
    quantum_load = 1'b0;
    run_to_save(100);
    check("qload_zero_ignored", cyc, 18);

    // ---------------- reset during SAVE ----------------
    do_reset();
    quantum_load = 1'b1; quantum_val = 8'd3;
    inst = OP_PRE_ON;
    tick();
    quantum_load = 1'b0;
    inst = OP_NOP;
    cyc = 1;
    run_to_save(50);
    check("rsave_save_cycle", cyc, 4);
    reset = 1'b1;
    #1;
    check("rsave_save_pc", save_pc, 0);
    check("rsave_preempt_en", preempt_en, 0);
    check("rsave_cause", cause, 0);
    tick();
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ctx_switch) seen++;
    end
    check("rsave_no_switch", seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_preempt_irq_ctrl
`default_nettype wire
